// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, FSM state encoding and bus widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_pkg;

  localparam int CMD_W  = 4;
  localparam int ADDR_W = 13;
  localparam int BANK_W = 2;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  // True while some master owns the SDRAM pins.
  function automatic logic is_grant(input state_t s);
    return (s == ST_AREF) || (s == ST_WRITE) || (s == ST_READ);
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval counter that raises ref_pend once per REF_CYC cycles.
// Latency: ref_pend rises the cycle after the counter reaches REF_CYC-1.
// Backpressure: none; an expiry while ref_pend is already set is absorbed.
module sdram_ref_timer #(
  parameter int REF_CYC = 780
) (
  input  logic sclk,
  input  logic sys_rstn,
  input  logic run,
  input  logic ack,
  output logic ref_pend
);

  localparam int CNT_W = (REF_CYC > 1) ? $clog2(REF_CYC) : 1;

  logic [CNT_W-1:0] cnt;
  logic             expire;

  assign expire = run && (cnt == CNT_W'(REF_CYC - 1));

  // Interval counter: advances only once init has finished, wraps at terminal count.
  always_ff @(posedge sclk or posedge sys_rstn) begin
    if (sys_rstn) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= expire ? '0 : cnt + 1'b1;
    end
  end

  // Pending flag: a fresh expiry wins over the acknowledge so no refresh is lost.
  always_ff @(posedge sclk or posedge sys_rstn) begin
    if (sys_rstn) begin
      ref_pend <= 1'b0;
    end else if (expire) begin
      ref_pend <= 1'b1;
    end else if (ack) begin
      ref_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants init/refresh/write/read masters (refresh > write > read) and muxes their bus.
// Latency: trig to grant 2 cycles; end to next grant 2 cycles; bus mux is combinational (0 cycles).
// Backpressure: requests queue as single pending flags; ref_due asks the active master to yield. Watchdog: SDRAM_ARB_WDOG_EN.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int REF_CYC  = 780,
  parameter int WDOG_CYC = 1024
) (
  input  logic              sclk,
  input  logic              sys_rstn,
  input  logic              init_done,
  input  logic [CMD_W-1:0]  init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              wr_trig,
  input  logic              rd_trig,
  input  logic              aref_end,
  input  logic              wr_end,
  input  logic              rd_end,
  input  logic [CMD_W-1:0]  aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic [CMD_W-1:0]  wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [CMD_W-1:0]  rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              ref_due,
  output logic [CMD_W-1:0]  sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BANK_W-1:0] sdram_bank,
  output logic              wdog_err
);

  state_t state, next_state;
  logic   wr_pend, rd_pend, ref_pend;
  logic   ref_ack, wr_ack, rd_ack;
  logic   end_match;
  logic   wdog_hit;

  // Entry cycles: the pending flag for the granted master clears on the same edge the grant starts.
  assign ref_ack = (state == ST_ARBIT) && (next_state == ST_AREF);
  assign wr_ack  = (state == ST_ARBIT) && (next_state == ST_WRITE);
  assign rd_ack  = (state == ST_ARBIT) && (next_state == ST_READ);

  assign end_match = ((state == ST_AREF)  && aref_end) ||
                     ((state == ST_WRITE) && wr_end)   ||
                     ((state == ST_READ)  && rd_end);

  sdram_ref_timer #(
    .REF_CYC (REF_CYC)
  ) u_ref_timer (
    .sclk     (sclk),
    .sys_rstn (sys_rstn),
    .run      (state != ST_INIT),
    .ack      (ref_ack),
    .ref_pend (ref_pend)
  );

  // Request latches: a trig on the entry cycle keeps the flag set, queueing one more transaction.
  always_ff @(posedge sclk or posedge sys_rstn) begin
    if (sys_rstn) begin
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      wr_pend <= wr_trig | (wr_pend & ~wr_ack);
      rd_pend <= rd_trig | (rd_pend & ~rd_ack);
    end
  end

`ifdef SDRAM_ARB_WDOG_EN
  localparam int WD_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

  logic [WD_W-1:0] wdog_cnt;
  logic            wdog_err_q;

  assign wdog_hit = is_grant(state) && (wdog_cnt == WD_W'(WDOG_CYC - 1));

  // Grant-age counter: zero on entry, one count per granted cycle.
  always_ff @(posedge sclk or posedge sys_rstn) begin
    if (sys_rstn) begin
      wdog_cnt <= '0;
    end else if (!is_grant(state)) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  // Timeout pulse: only when the grant is revoked, not when the master ended on its last allowed cycle.
  always_ff @(posedge sclk or posedge sys_rstn) begin
    if (sys_rstn) begin
      wdog_err_q <= 1'b0;
    end else begin
      wdog_err_q <= wdog_hit & ~end_match;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge sclk or posedge sys_rstn) begin
    if (sys_rstn) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next state: fixed priority in ARBIT, masters leave on their own end pulse or on watchdog.
  always_comb begin
    next_state = state;
    case (state)
      ST_INIT:  if (init_done) next_state = ST_ARBIT;
      ST_ARBIT: begin
        if (ref_pend)     next_state = ST_AREF;
        else if (wr_pend) next_state = ST_WRITE;
        else if (rd_pend) next_state = ST_READ;
      end
      ST_AREF, ST_WRITE, ST_READ: begin
        if (end_match || wdog_hit) next_state = ST_ARBIT;
      end
      default:  next_state = ST_INIT;
    endcase
  end

  assign aref_en = (state == ST_AREF);
  assign wr_en   = (state == ST_WRITE);
  assign rd_en   = (state == ST_READ);
  assign ref_due = ref_pend && ((state == ST_WRITE) || (state == ST_READ));

  // Pin mux: the owning master drives the pins in the same cycle; ARBIT idles with NOP.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    case (state)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      ST_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Testbench for sdram_arbit: directed scenarios push expected grants; a monitor checks each grant as it appears.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdram_arbit;
  import sdram_pkg::*;

  localparam logic [CMD_W-1:0]  INIT_CMD  = 4'b0010;
  localparam logic [ADDR_W-1:0] INIT_ADDR = 13'h0400;
  localparam logic [CMD_W-1:0]  AREF_CMD  = 4'b0001;
  localparam logic [ADDR_W-1:0] AREF_ADDR = 13'h0aaa;
  localparam logic [CMD_W-1:0]  WR_CMD    = 4'b0100;
  localparam logic [ADDR_W-1:0] WR_ADDR   = 13'h0123;
  localparam logic [BANK_W-1:0] WR_BANK   = 2'd2;
  localparam logic [CMD_W-1:0]  RD_CMD    = 4'b0101;
  localparam logic [ADDR_W-1:0] RD_ADDR   = 13'h1456;
  localparam logic [BANK_W-1:0] RD_BANK   = 2'd3;

  localparam int K_AREF = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;

  logic              sclk;
  logic              sys_rstn;
  logic              init_done;
  logic              wr_trig, rd_trig;
  logic              aref_end, wr_end, rd_end;
  logic              aref_en, wr_en, rd_en, ref_due, wdog_err;
  logic [CMD_W-1:0]  sdram_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [BANK_W-1:0] sdram_bank;

  sdram_arbit #(
    .REF_CYC  (16),
    .WDOG_CYC (8)
  ) dut (
    .sclk       (sclk),
    .sys_rstn   (sys_rstn),
    .init_done  (init_done),
    .init_cmd   (INIT_CMD),
    .init_addr  (INIT_ADDR),
    .wr_trig    (wr_trig),
    .rd_trig    (rd_trig),
    .aref_end   (aref_end),
    .wr_end     (wr_end),
    .rd_end     (rd_end),
    .aref_cmd   (AREF_CMD),
    .aref_addr  (AREF_ADDR),
    .wr_cmd     (WR_CMD),
    .wr_addr    (WR_ADDR),
    .wr_bank    (WR_BANK),
    .rd_cmd     (RD_CMD),
    .rd_addr    (RD_ADDR),
    .rd_bank    (RD_BANK),
    .aref_en    (aref_en),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .ref_due    (ref_due),
    .sdram_cmd  (sdram_cmd),
    .sdram_addr (sdram_addr),
    .sdram_bank (sdram_bank),
    .wdog_err   (wdog_err)
  );

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  logic [2:0] g_prev = 3'b000;

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_grant(input int kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Advance one cycle; pulse inputs only last the cycle they were driven in.
  task automatic step();
    @(negedge sclk);
    wr_trig  = 1'b0;
    rd_trig  = 1'b0;
    aref_end = 1'b0;
    wr_end   = 1'b0;
    rd_end   = 1'b0;
  endtask

  task automatic at(input int n);
    while (cyc < n) step();
  endtask

  // Monitor: every rising grant must match the head of the expectation queue, with that master on the pins.
  always @(negedge sclk) begin
    logic [2:0] g;
    exp_t e;
    g = {rd_en, wr_en, aref_en};
    chk("grant_onehot", {31'd0, $onehot0(g)}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      if (g[k] && !g_prev[k]) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_grant @cyc %0d: got grant kind %0d, expected none", cyc, k);
        end else begin
          e = exp_q.pop_front();
          chk("grant_kind", k, e.kind);
          chk("grant_cycle", cyc, e.cyc);
          case (k)
            K_AREF: begin
              chk("aref_bus_cmd", sdram_cmd, AREF_CMD);
              chk("aref_bus_addr", sdram_addr, AREF_ADDR);
              chk("aref_bus_bank", sdram_bank, 0);
            end
            K_WR: begin
              chk("wr_bus_cmd", sdram_cmd, WR_CMD);
              chk("wr_bus_addr", sdram_addr, WR_ADDR);
              chk("wr_bus_bank", sdram_bank, WR_BANK);
            end
            default: begin
              chk("rd_bus_cmd", sdram_cmd, RD_CMD);
              chk("rd_bus_addr", sdram_addr, RD_ADDR);
              chk("rd_bus_bank", sdram_bank, RD_BANK);
            end
          endcase
        end
      end
    end
    g_prev = g;
  end

  // Reset, release, init_done at cycle 9 after release; returns the first ARBIT cycle.
  task automatic reset_init(output int a);
    int r;
    step();
    sys_rstn  = 1'b1;
    init_done = 1'b0;
    step();
    step();
    chk("rst_aref_en", aref_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_ref_due", ref_due, 0);
    chk("rst_wdog_err", wdog_err, 0);
    chk("rst_cmd", sdram_cmd, INIT_CMD);
    chk("rst_addr", sdram_addr, INIT_ADDR);
    chk("rst_bank", sdram_bank, 0);
    sys_rstn = 1'b0;
    r = cyc;
    at(r + 9);
    chk("init_cmd_hold", sdram_cmd, INIT_CMD);
    init_done = 1'b1;
    at(r + 10);
    chk("arbit_nop", sdram_cmd, CMD_NOP);
    chk("arbit_addr", sdram_addr, 0);
    chk("arbit_no_grant", {aref_en, wr_en, rd_en}, 0);
    a = r + 10;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    int r;
    sys_rstn  = 1'b1;
    init_done = 1'b0;
    wr_trig   = 1'b0;
    rd_trig   = 1'b0;
    aref_end  = 1'b0;
    wr_end    = 1'b0;
    rd_end    = 1'b0;

    // Simultaneous write and read requests: write first, read 2 cycles after wr_end.
    reset_init(a);
    at(a + 1); wr_trig = 1'b1; rd_trig = 1'b1;
    expect_grant(K_WR, a + 3);
    expect_grant(K_RD, a + 7);
    expect_grant(K_AREF, a + 17);
    at(a + 5); wr_end = 1'b1;
    at(a + 6);
    chk("s1_gap_wr_en", wr_en, 0);
    chk("s1_gap_rd_en", rd_en, 0);
    chk("s1_gap_nop", sdram_cmd, CMD_NOP);
    at(a + 8); rd_end = 1'b1;
    at(a + 18); aref_end = 1'b1;
    at(a + 19); chk("s1_aref_done", aref_en, 0);

    // Refresh expires during a write: ref_due, then AREF ahead of the waiting read.
    reset_init(a);
    at(a + 10); wr_trig = 1'b1; rd_trig = 1'b1;
    expect_grant(K_WR, a + 12);
    expect_grant(K_AREF, a + 19);
    expect_grant(K_RD, a + 22);
    at(a + 15); chk("s2_ref_due_before", ref_due, 0);
    at(a + 16);
    chk("s2_ref_due_set", ref_due, 1);
    chk("s2_wr_held", wr_en, 1);
    at(a + 17); wr_end = 1'b1;
    at(a + 18);
    chk("s2_gap_ref_due", ref_due, 0);
    chk("s2_gap_nop", sdram_cmd, CMD_NOP);
    at(a + 19);
    chk("s2_aref_cmd", sdram_cmd, AREF_CMD);
    chk("s2_aref_ref_due", ref_due, 0);
    chk("s2_rd_waits", rd_en, 0);
    at(a + 20); aref_end = 1'b1;
    at(a + 23); rd_end = 1'b1;
    at(a + 24); chk("s2_rd_done", rd_en, 0);

    // Write retriggers: entry-cycle trig queues one more, a trig while pending is absorbed.
    reset_init(a);
    at(a + 1); wr_trig = 1'b1;
    expect_grant(K_WR, a + 3);
    at(a + 2); wr_trig = 1'b1;
    at(a + 4); wr_trig = 1'b1;
    at(a + 6); wr_end = 1'b1;
    expect_grant(K_WR, a + 8);
    expect_grant(K_AREF, a + 17);
    at(a + 7);
    chk("s3_gap_wr_en", wr_en, 0);
    chk("s3_gap_nop", sdram_cmd, CMD_NOP);
    at(a + 10); wr_end = 1'b1;
    at(a + 15); chk("s3_no_third_wr", wr_en, 0);
    at(a + 18); aref_end = 1'b1;
    at(a + 19); chk("s3_idle", {aref_en, wr_en, rd_en}, 0);

    // Write master never ends: watchdog revokes after 8 cycles, or the grant is held.
    reset_init(a);
    at(a + 1); wr_trig = 1'b1; rd_trig = 1'b1;
    expect_grant(K_WR, a + 3);
`ifdef SDRAM_ARB_WDOG_EN
    expect_grant(K_RD, a + 12);
    expect_grant(K_AREF, a + 17);
    at(a + 10);
    chk("s4_wr_last_cycle", wr_en, 1);
    chk("s4_wdog_quiet", wdog_err, 0);
    at(a + 11);
    chk("s4_wr_revoked", wr_en, 0);
    chk("s4_wdog_pulse", wdog_err, 1);
    chk("s4_revoke_nop", sdram_cmd, CMD_NOP);
    at(a + 12);
    chk("s4_wdog_one_cycle", wdog_err, 0);
    at(a + 13); rd_end = 1'b1;
`else
    expect_grant(K_RD, a + 14);
    expect_grant(K_AREF, a + 17);
    at(a + 11);
    chk("s4_wr_held", wr_en, 1);
    chk("s4_wdog_tied", wdog_err, 0);
    at(a + 12); wr_end = 1'b1;
    at(a + 15); rd_end = 1'b1;
`endif
    at(a + 18); aref_end = 1'b1;
    at(a + 19); chk("s4_idle", {aref_en, wr_en, rd_en}, 0);

    // Reset in the middle of a read drops the grant at once and loses the queued write.
    reset_init(a);
    at(a + 1); rd_trig = 1'b1;
    expect_grant(K_RD, a + 3);
    at(a + 3); wr_trig = 1'b1;
    at(a + 4);
    chk("s5_rd_before_rst", rd_en, 1);
    sys_rstn = 1'b1;
    #1;
    chk("s5_rd_async_drop", rd_en, 0);
    chk("s5_rst_cmd", sdram_cmd, INIT_CMD);
    chk("s5_rst_wdog", wdog_err, 0);
    step();
    sys_rstn = 1'b0;
    r = cyc;
    at(r + 1);
    chk("s5_arbit_nop", sdram_cmd, CMD_NOP);
    chk("s5_no_grant_early", {aref_en, wr_en, rd_en}, 0);
    at(r + 10);
    chk("s5_no_grant_late", {aref_en, wr_en, rd_en}, 0);

    at(cyc + 2);
    chk("all_expected_grants_seen", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
